uart_cmd_ctrl: RTL



---
 rtl/uart_cmd_ctrl_if.sv | 12 +
 rtl/uart_cmd_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream handshake between the UART RX/TX blocks and the command sequencer.
// The master side drives received bytes and transmitter status; the slave side returns responses.
interface uart_cmd_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       TX_BUSY;
    logic [7:0] TX_DATA;
    logic       TX_START;

    modport master (output RX_DATA, RX_VALID, TX_BUSY, input TX_DATA, TX_START);
    modport slave  (input RX_DATA, RX_VALID, TX_BUSY, output TX_DATA, TX_START);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Framed command sequencer: parses HDR/CMD/ADDR[/DATA] bytes, accesses a small register
// file and returns one response byte per frame through the TX start/busy handshake.
module uart_cmd_ctrl #(
    parameter int         NREG        = 4,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] HDR         = 8'hA5,
    parameter logic [7:0] ACK         = 8'h06,
    parameter logic [7:0] NAK         = 8'h15
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    uart_cmd_if.slave      bus,
    output logic [7:0]     LED,
    output logic [3:0]     STATE
);
    localparam int             CW       = $clog2(TIMEOUT_CYC + 1);
    localparam int             AW       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     CMD_WR   = 8'h01;
    localparam logic [7:0]     CMD_RD   = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_CMD  = 4'd1,
        ST_ADDR = 4'd2,
        ST_DATA = 4'd3,
        ST_RESP = 4'd4
    } state_t;

    state_t          state_r, state_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic [7:0]      cmd_r, cmd_n;
    logic [AW-1:0]   addr_r, addr_n;
    logic [7:0]      resp_r, resp_n;
    logic [7:0]      tx_data_r;
    logic            tx_start_r;
    logic [7:0]      regs_r [NREG];
    logic            wr_en_s;
    logic            start_s;
    logic            addr_ok_s;
    logic [7:0]      rd_data_s;

    assign addr_ok_s = ({1'b0, bus.RX_DATA} < 9'(NREG));
    assign rd_data_s = regs_r[bus.RX_DATA[AW-1:0]];

    // Next-state, timeout counter and latched frame fields.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        cmd_n   = cmd_r;
        addr_n  = addr_r;
        resp_n  = resp_r;
        wr_en_s = 1'b0;
        start_s = 1'b0;
        if (!EN) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_n = '0;
                    if (bus.RX_VALID && (bus.RX_DATA == HDR)) begin
                        state_n = ST_CMD;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (!bus.RX_VALID) begin
                        if (cnt_r == CNT_LAST) begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_r + CW'(1);
                        end
                    end else begin
                        cnt_n = '0;
                        case (state_r)
                            ST_CMD: begin
                                if ((bus.RX_DATA == CMD_WR) || (bus.RX_DATA == CMD_RD)) begin
                                    cmd_n   = bus.RX_DATA;
                                    state_n = ST_ADDR;
                                end else begin
                                    resp_n  = NAK;
                                    state_n = ST_RESP;
                                end
                            end
                            ST_ADDR: begin
                                if (!addr_ok_s) begin
                                    resp_n  = NAK;
                                    state_n = ST_RESP;
                                end else if (cmd_r == CMD_WR) begin
                                    addr_n  = bus.RX_DATA[AW-1:0];
                                    state_n = ST_DATA;
                                end else begin
                                    resp_n  = rd_data_s;
                                    state_n = ST_RESP;
                                end
                            end
                            default: begin
                                wr_en_s = 1'b1;
                                resp_n  = ACK;
                                state_n = ST_RESP;
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    // Bytes arriving here are dropped; only the transmitter status matters.
                    cnt_n = '0;
                    if (!bus.TX_BUSY) begin
                        start_s = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_RESP;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // State, frame fields, response output and register file.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            cmd_r      <= 8'h00;
            addr_r     <= '0;
            resp_r     <= 8'h00;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            cmd_r      <= cmd_n;
            addr_r     <= addr_n;
            resp_r     <= resp_n;
            tx_start_r <= start_s;
            if (start_s) begin
                tx_data_r <= resp_r;
            end
            if (wr_en_s) begin
                regs_r[addr_r] <= bus.RX_DATA;
            end
        end
    end

    assign bus.TX_DATA  = tx_data_r;
    assign bus.TX_START = tx_start_r;
    assign LED          = regs_r[0];
    assign STATE        = state_r;
endmodule
